net_debounce: RTL and testbench
===============================

Name: net_debounce

Overview:
- Upstream conditioning stage for single-bit consumer modules whose input port is named `d`.
- Synchronizes an asynchronous raw level into `clk` and debounces it.
- Drives a clean registered level on output `d`, so parent modules can use the implicit `.d` connection to the consumer.
- Also reports a busy flag and a saturating glitch counter for debug.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal: >= 2).
- STABLE_CYCLES, 8, consecutive stable synchronized samples required to accept a new level (legal: >= 2).
- RESET_VAL, 1'b0, reset value of the synchronizer flops and of `d`.

Ports:
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous, active-low reset.
- raw_in  input  1  asynchronous raw level (pin, other domain).
- d  output  1  debounced registered level; feeds the downstream consumer's `d`.
- busy  output  1  high while a candidate level change is being confirmed.
- glitch_cnt  output  8  count of rejected transitions; saturates at 255.

Behaviour:
- Reset (async assert, sync deassert via external logic):
  - sync flops = RESET_VAL; d = RESET_VAL; busy = 0; glitch_cnt = 0.
  - state = STABLE; internal cnt = 0.
- Synchronizer: `s` is the output of the SYNC_STAGES-deep flop chain sampling raw_in. Nothing else samples raw_in.
- FSM states: STABLE, CONFIRM.
  - STABLE, s == d: remain; cnt = 0.
  - STABLE, s != d: go to CONFIRM; cnt <= 1.
  - CONFIRM, s == d: glitch. Return to STABLE; cnt <= 0; glitch_cnt <= glitch_cnt + 1 unless already 255.
  - CONFIRM, s != d and cnt == STABLE_CYCLES-1: d <= s; go to STABLE; cnt <= 0.
  - CONFIRM, s != d otherwise: cnt <= cnt + 1.
- cnt width: $clog2(STABLE_CYCLES); cnt never exceeds STABLE_CYCLES-1.
- busy: combinational from state (busy = state == CONFIRM). It is 0 in the cycle after d updates.
- Latency: if raw_in changes and then holds, d changes on clock edge SYNC_STAGES+STABLE_CYCLES, counting the first edge that samples the new value as edge 1. With defaults that is edge 10.
- A pulse shorter than STABLE_CYCLES synchronized samples never reaches d and increments glitch_cnt by exactly 1.
- A toggle during CONFIRM restarts the qualification from STABLE; there is no partial credit.
- glitch_cnt at 255 holds at 255. It is never cleared except by reset.
- Reset asserted mid-CONFIRM: immediate return to reset values; the pending change is discarded.
- If raw_in == RESET_VAL at reset release, d does not toggle.

Optional Feature:
- Macro: NET_DEBOUNCE_EDGE_EN.
- When defined, adds two output ports, each 1 bit:
  - rise_pulse is high for exactly the one cycle in which d is 1 and was 0 the previous cycle.
  - fall_pulse is the converse.
  - Both are registered alongside d (same edge as the d update, not a cycle later). Both reset to 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package net_debounce_pkg:
  - state enum typedef net_db_state_e {STABLE, CONFIRM}.
  - localparam GLITCH_W = 8.
  - localparam GLITCH_MAX = 8'hFF.
- Sub-module net_sync (params STAGES, RESET_VAL; ports clk, rst_n, async_in, sync_out) holds the flop chain and is reused by other single-bit crossing stages.
- Top level holds the FSM, counter and glitch counter.

Test Plan:
- Reset release with raw_in=0, RESET_VAL=0 -> d=0, busy=0, glitch_cnt=0 for 20 cycles.
- raw_in 0->1 and held -> busy rises after edge 3; d=1 exactly at edge 10; busy=0 after; glitch_cnt=0.
- raw_in high for 5 cycles then low -> d stays 0; glitch_cnt=1; busy returns to 0.
- 300 short 3-cycle pulses -> d never changes; glitch_cnt=255 (saturated, no wrap).
- raw_in goes high; rst_n asserted at edge 7 -> d=0, busy=0, cnt cleared. After release with raw_in still 1 -> d=1 at edge 10 measured from release.
- With NET_DEBOUNCE_EDGE_EN, accepted 0->1 then 1->0 -> rise_pulse high one cycle coincident with d rising; fall_pulse likewise with d falling; never both high together.

Source files
------------

// File: rtl/net_debounce_pkg.sv
// Shared types and constants for the net_debounce input conditioning stage.
// Optional edge-pulse outputs in the top are enabled by NET_DEBOUNCE_EDGE_EN.
package net_debounce_pkg;

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        CONFIRM = 1'b1
    } net_db_state_e;

    localparam int GLITCH_W = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;

    // Saturating increment for the debug glitch counter.
    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] value);
        logic [GLITCH_W-1:0] result;
        if (value == GLITCH_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/net_sync.sv
// Multi-flop synchronizer bringing a single asynchronous bit into clk.
// Reused by any single-bit crossing stage; the chain depth is STAGES.
module net_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] chain_r;

    // Shift the raw level through the flop chain; bit 0 is the only flop touching async_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {STAGES{RESET_VAL}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain_r[STAGES-1];

endmodule

// File: rtl/net_debounce.sv
// Synchronize and debounce a raw level into a clean registered output d.
// Define NET_DEBOUNCE_EDGE_EN to add rise_pulse/fall_pulse outputs.
module net_debounce
    import net_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 8,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                raw_in,
    output logic                d,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
`ifdef NET_DEBOUNCE_EDGE_EN
    ,
    output logic                rise_pulse,
    output logic                fall_pulse
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic                sync_s;
    net_db_state_e       state_r;
    net_db_state_e       state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic                d_r;
    logic                d_nxt_s;
    logic [GLITCH_W-1:0] glitch_r;
    logic [GLITCH_W-1:0] glitch_nxt_s;

    net_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (raw_in),
        .sync_out (sync_s)
    );

    // Qualification FSM: a change must persist STABLE_CYCLES samples; any reversion counts as a glitch.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        d_nxt_s      = d_r;
        glitch_nxt_s = glitch_r;
        case (state_r)
            STABLE: begin
                if (sync_s != d_r) begin
                    state_nxt_s = CONFIRM;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            CONFIRM: begin
                if (sync_s == d_r) begin
                    state_nxt_s  = STABLE;
                    cnt_nxt_s    = CNT_ZERO;
                    glitch_nxt_s = sat_inc(glitch_r);
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s  = STABLE;
                    cnt_nxt_s    = CNT_ZERO;
                    d_nxt_s      = sync_s;
                end else begin
                    cnt_nxt_s    = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = STABLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and output registers; reset discards any pending change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= STABLE;
            cnt_r    <= CNT_ZERO;
            d_r      <= RESET_VAL;
            glitch_r <= {GLITCH_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            d_r      <= d_nxt_s;
            glitch_r <= glitch_nxt_s;
        end
    end

`ifdef NET_DEBOUNCE_EDGE_EN
    logic rise_r;
    logic fall_r;

    // Edge pulses register on the same edge as the d update they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= d_nxt_s & ~d_r;
            fall_r <= ~d_nxt_s & d_r;
        end
    end

    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
`endif

    assign d          = d_r;
    assign busy       = (state_r == CONFIRM);
    assign glitch_cnt = glitch_r;

endmodule

// File: tb/tb_net_debounce.sv
// Randomized scoreboard bench for net_debounce against a run-length reference model.
module tb_net_debounce;

    localparam int SYNC = 2;
    localparam int STAB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       raw_in = 1'b0;
    logic       d;
    logic       busy;
    logic [7:0] glitch_cnt;
`ifdef NET_DEBOUNCE_EDGE_EN
    logic       rise_pulse;
    logic       fall_pulse;
`endif

    net_debounce #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STAB),
        .RESET_VAL     (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .d          (d),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
`ifdef NET_DEBOUNCE_EDGE_EN
        ,
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       d;
        logic       busy;
        logic [7:0] gc;
        logic       rise;
        logic       fall;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: delay line for the synchronizer, run length of disagreeing samples.
    logic m_pipe [SYNC];
    logic m_d;
    int   m_run;
    int   m_gc;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
        m_d   = 1'b0;
        m_run = 0;
        m_gc  = 0;
    endtask

    task automatic model_step(output exp_t e);
        logic s;
        logic old_d;
        s     = m_pipe[SYNC-1];
        old_d = m_d;
        if (s != m_d) begin
            m_run++;
            if (m_run == STAB) begin
                m_d   = s;
                m_run = 0;
            end
        end else begin
            if (m_run > 0 && m_gc < 255) m_gc++;
            m_run = 0;
        end
        for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = raw_in;
        e.d    = m_d;
        e.busy = (m_run > 0);
        e.gc   = 8'(m_gc);
        e.rise = m_d & ~old_d;
        e.fall = ~m_d & old_d;
    endtask

    // Drive one cycle (also releases reset) and queue the expected result of the next edge.
    task automatic drive(input logic v);
        exp_t e;
        @(negedge clk);
        rst_n  = 1'b1;
        raw_in = v;
        model_step(e);
        exp_q.push_back(e);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    // Monitor: pops one expectation per active clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("d", {7'd0, d}, {7'd0, e.d});
            check("busy", {7'd0, busy}, {7'd0, e.busy});
            check("glitch_cnt", glitch_cnt, e.gc);
`ifdef NET_DEBOUNCE_EDGE_EN
            check("rise_pulse", {7'd0, rise_pulse}, {7'd0, e.rise});
            check("fall_pulse", {7'd0, fall_pulse}, {7'd0, e.fall});
            check("rise_fall_excl", {7'd0, rise_pulse & fall_pulse}, 8'd0);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        logic seen;
        model_reset();
        rst_n  = 1'b0;
        raw_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_d", {7'd0, d}, 8'd0);
        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_gc", glitch_cnt, 8'd0);

        // Quiet input after release.
        repeat (20) drive(1'b0);
        @(posedge clk); #2;
        check("quiet_d", {7'd0, d}, 8'd0);
        check("quiet_gc", glitch_cnt, 8'd0);

        // Clean rising change: d must rise on edge 10.
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            drive(1'b1);
            @(posedge clk); #2;
            if (k == 4) check("busy_confirm", {7'd0, busy}, 8'd1);
            if (d) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check("rise_latency", 8'(lat), 8'd10);
        check("busy_after_accept", {7'd0, busy}, 8'd0);
        repeat (4) drive(1'b1);
        repeat (14) drive(1'b0);
        @(posedge clk); #2;
        check("fall_accepted", {7'd0, d}, 8'd0);
        check("clean_gc", glitch_cnt, 8'd0);

        // Short pulse is rejected once.
        repeat (5) drive(1'b1);
        repeat (10) drive(1'b0);
        @(posedge clk); #2;
        check("glitch_d", {7'd0, d}, 8'd0);
        check("glitch_gc", glitch_cnt, 8'd1);
        check("glitch_busy", {7'd0, busy}, 8'd0);

        // Saturation with many short pulses.
        for (int p = 0; p < 300; p++) begin
            repeat (3) drive(1'b1);
            repeat (3) drive(1'b0);
        end
        repeat (4) drive(1'b0);
        @(posedge clk); #2;
        check("sat_gc", glitch_cnt, 8'd255);
        check("sat_d", {7'd0, d}, 8'd0);

        // Reset during CONFIRM discards the pending change.
        repeat (6) drive(1'b1);
        @(posedge clk); #3;
        check("pre_reset_busy", {7'd0, busy}, 8'd1);
        assert_reset();
        #1;
        check("midreset_d", {7'd0, d}, 8'd0);
        check("midreset_busy", {7'd0, busy}, 8'd0);
        check("midreset_gc", glitch_cnt, 8'd0);
        repeat (2) @(negedge clk);
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            drive(1'b1);
            @(posedge clk); #2;
            if (d) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check("post_reset_latency", 8'(lat), 8'd10);

        // Randomized segments of varying hold length.
        for (int seg = 0; seg < 150; seg++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            repeat (len) drive(v);
        end
        repeat (3) drive(raw_in);
        @(posedge clk); #3;
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
